// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM word bridge and its downstream controller:
// address widths, burst length and the bridge state encoding.
package sdram_pkg;

  localparam int SDRAM_CPU_ADDR_W   = 23;
  localparam int SDRAM_DBUS_ADDR_W  = SDRAM_CPU_ADDR_W + 2;
  localparam int SDRAM_BURSTCOUNT_W = 7;
  localparam int BRIDGE_BURST       = 2;

  typedef enum logic [2:0] {
    BR_IDLE,
    BR_WR_LO,
    BR_WR_HI,
    BR_RD_REQ,
    BR_RD_LO,
    BR_RD_HI
  } bridge_state_e;

endpackage

// File: rtl/sdram_word_bridge.sv
// Splits single-outstanding 32-bit CPU accesses into 2-beat 16-bit bursts
// (low halfword first) and reassembles read data for the CPU.
module sdram_word_bridge
  import sdram_pkg::*;
#(
  parameter int CPU_ADDR_W   = SDRAM_CPU_ADDR_W,
  parameter int DBUS_ADDR_W  = SDRAM_DBUS_ADDR_W,
  parameter int BURSTCOUNT_W = SDRAM_BURSTCOUNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_done,
  input  logic [CPU_ADDR_W-1:0]   cpu_address,
  input  logic [31:0]             cpu_writedata,
  input  logic [3:0]              cpu_byteenable,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  output logic                    cpu_waitrequest,
  output logic [31:0]             cpu_readdata,
  output logic                    cpu_readdatavalid,
  output logic [DBUS_ADDR_W-1:0]  dbus_address,
  output logic [15:0]             dbus_writedata,
  output logic [1:0]              dbus_byteenable,
  output logic [BURSTCOUNT_W-1:0] dbus_burstcount,
  output logic                    dbus_read,
  output logic                    dbus_write,
  input  logic                    dbus_waitrequest,
  input  logic [15:0]             dbus_readdata,
  input  logic                    dbus_readdatavalid
);

  bridge_state_e          state_q, state_d;
  logic [DBUS_ADDR_W-1:0] address_q, address_d;
  logic [15:0]            writedata_q, writedata_d;
  logic [1:0]             byteenable_q, byteenable_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic [15:0]            wd_hi_q, wd_hi_d;
  logic [1:0]             be_hi_q, be_hi_d;
  logic [15:0]            rd_lo_q, rd_lo_d;
  logic [31:0]            readdata_q, readdata_d;
  logic                   readvalid_q, readvalid_d;
  logic                   accept;

  assign cpu_waitrequest   = !(state_q == BR_IDLE && init_done);
  assign accept            = (cpu_read || cpu_write) && !cpu_waitrequest;
  assign cpu_readdata      = readdata_q;
  assign cpu_readdatavalid = readvalid_q;
  assign dbus_address      = address_q;
  assign dbus_writedata    = writedata_q;
  assign dbus_byteenable   = byteenable_q;
  assign dbus_burstcount   = BURSTCOUNT_W'(BRIDGE_BURST);
  assign dbus_read         = read_q;
  assign dbus_write        = write_q;

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    wd_hi_d      = wd_hi_q;
    be_hi_d      = be_hi_q;
    rd_lo_d      = rd_lo_q;
    readdata_d   = readdata_q;
    readvalid_d  = 1'b0;

    case (state_q)
      BR_IDLE: begin
        if (accept) begin
          address_d = DBUS_ADDR_W'({cpu_address, 2'b00});
          wd_hi_d   = cpu_writedata[31:16];
          be_hi_d   = cpu_byteenable[3:2];
          // Write has priority when both strobes are raised together.
          if (cpu_write) begin
            state_d      = BR_WR_LO;
            write_d      = 1'b1;
            writedata_d  = cpu_writedata[15:0];
            byteenable_d = cpu_byteenable[1:0];
          end else begin
            state_d = BR_RD_REQ;
            read_d  = 1'b1;
          end
        end
      end
      BR_WR_LO: begin
        if (!dbus_waitrequest) begin
          state_d      = BR_WR_HI;
          writedata_d  = wd_hi_q;
          byteenable_d = be_hi_q;
        end
      end
      BR_WR_HI: begin
        if (!dbus_waitrequest) begin
          state_d = BR_IDLE;
          write_d = 1'b0;
        end
      end
      BR_RD_REQ: begin
        if (!dbus_waitrequest) begin
          read_d = 1'b0;
          // A low beat returned on the acceptance cycle must not be lost.
          if (dbus_readdatavalid) begin
            rd_lo_d = dbus_readdata;
            state_d = BR_RD_HI;
          end else begin
            state_d = BR_RD_LO;
          end
        end
      end
      BR_RD_LO: begin
        if (dbus_readdatavalid) begin
          rd_lo_d = dbus_readdata;
          state_d = BR_RD_HI;
        end
      end
      BR_RD_HI: begin
        if (dbus_readdatavalid) begin
          readdata_d  = {dbus_readdata, rd_lo_q};
          readvalid_d = 1'b1;
          state_d     = BR_IDLE;
        end
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= BR_IDLE;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      wd_hi_q      <= '0;
      be_hi_q      <= '0;
      rd_lo_q      <= '0;
      readdata_q   <= '0;
      readvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      wd_hi_q      <= wd_hi_d;
      be_hi_q      <= be_hi_d;
      rd_lo_q      <= rd_lo_d;
      readdata_q   <= readdata_d;
      readvalid_q  <= readvalid_d;
    end
  end

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Directed bench for sdram_word_bridge: the bench plays CPU and SDRAM controller,
// driving on the falling edge and checking against hand-computed values.
module tb_sdram_word_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [22:0] cpu_address;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_read;
  logic        cpu_write;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [24:0] dbus_address;
  logic [15:0] dbus_writedata;
  logic [1:0]  dbus_byteenable;
  logic [6:0]  dbus_burstcount;
  logic        dbus_read;
  logic        dbus_write;
  logic        dbus_waitrequest;
  logic [15:0] dbus_readdata;
  logic        dbus_readdatavalid;

  int checks = 0;
  int errors = 0;
  int rd_bursts = 0;
  logic [24:0] b_addr[$];
  logic [15:0] b_data[$];
  logic [1:0]  b_be[$];
  logic [6:0]  b_bc[$];

  always #5 clk = ~clk;

  sdram_word_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .init_done          (init_done),
    .cpu_address        (cpu_address),
    .cpu_writedata      (cpu_writedata),
    .cpu_byteenable     (cpu_byteenable),
    .cpu_read           (cpu_read),
    .cpu_write          (cpu_write),
    .cpu_waitrequest    (cpu_waitrequest),
    .cpu_readdata       (cpu_readdata),
    .cpu_readdatavalid  (cpu_readdatavalid),
    .dbus_address       (dbus_address),
    .dbus_writedata     (dbus_writedata),
    .dbus_byteenable    (dbus_byteenable),
    .dbus_burstcount    (dbus_burstcount),
    .dbus_read          (dbus_read),
    .dbus_write         (dbus_write),
    .dbus_waitrequest   (dbus_waitrequest),
    .dbus_readdata      (dbus_readdata),
    .dbus_readdatavalid (dbus_readdatavalid)
  );

  // Inputs are settled before this is called; log the handshakes the coming
  // rising edge will complete, then advance to the next falling edge.
  task automatic step();
    if (dbus_write && !dbus_waitrequest) begin
      b_addr.push_back(dbus_address);
      b_data.push_back(dbus_writedata);
      b_be.push_back(dbus_byteenable);
      b_bc.push_back(dbus_burstcount);
    end
    if (dbus_read && !dbus_waitrequest) rd_bursts++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_log();
    b_addr.delete(); b_data.delete(); b_be.delete(); b_bc.delete();
    rd_bursts = 0;
  endtask

  task automatic check_beat(input string name, input int idx, input logic [24:0] a,
                            input logic [15:0] d, input logic [1:0] be);
    checks++;
    if (b_addr.size() <= idx) begin
      errors++;
      $display("FAIL %s: beat %0d missing, got %0d beats", name, idx, b_addr.size());
    end else if (b_addr[idx] !== a || b_data[idx] !== d || b_be[idx] !== be || b_bc[idx] !== 7'd2) begin
      errors++;
      $display("FAIL %s: beat %0d got addr=%h data=%h be=%b bc=%0d, expected addr=%h data=%h be=%b bc=2",
               name, idx, b_addr[idx], b_data[idx], b_be[idx], b_bc[idx], a, d, be);
    end
  endtask

  // Issue one CPU write and serve both beats, stalling each beat `stall` cycles.
  task automatic do_write(input logic [22:0] addr, input logic [31:0] wd, input logic [3:0] be,
                          input int stall, output int wait_hi);
    logic [15:0] exp_d;
    logic [1:0]  exp_be;
    clear_log();
    cpu_address = addr; cpu_writedata = wd; cpu_byteenable = be; cpu_write = 1'b1;
    checks++;
    if (cpu_waitrequest !== 1'b0) begin
      errors++; $display("FAIL wr_accept: waitrequest=%b expected 0", cpu_waitrequest);
    end
    step();
    cpu_write = 1'b0; cpu_address = '0; cpu_writedata = 32'hDEADBEEF; cpu_byteenable = 4'h0;
    wait_hi = 0;
    for (int beat = 0; beat < 2; beat++) begin
      exp_d  = (beat == 0) ? wd[15:0] : wd[31:16];
      exp_be = (beat == 0) ? be[1:0] : be[3:2];
      for (int s = 0; s < stall; s++) begin
        dbus_waitrequest = 1'b1;
        checks++;
        if (dbus_write !== 1'b1 || dbus_writedata !== exp_d || dbus_byteenable !== exp_be
            || dbus_address !== {addr, 2'b00}) begin
          errors++;
          $display("FAIL wr_stall_hold: beat %0d got wr=%b data=%h be=%b addr=%h, expected wr=1 data=%h be=%b addr=%h",
                   beat, dbus_write, dbus_writedata, dbus_byteenable, dbus_address, exp_d, exp_be, {addr, 2'b00});
        end
        wait_hi += int'(cpu_waitrequest);
        step();
      end
      dbus_waitrequest = 1'b0;
      wait_hi += int'(cpu_waitrequest);
      step();
    end
    checks++;
    if (dbus_write !== 1'b0 || cpu_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: dbus_write=%b waitrequest=%b expected 0 0", dbus_write, cpu_waitrequest);
    end
  endtask

  // Issue one CPU read; the bench returns lo then hi after `lat` idle cycles,
  // or with the low beat on the request acceptance cycle when same_cycle is set.
  task automatic do_read(input string name, input logic [22:0] addr, input int lat, input bit same_cycle,
                         input logic [15:0] lo, input logic [15:0] hi, input logic [31:0] exp);
    clear_log();
    cpu_address = addr; cpu_read = 1'b1;
    step();
    cpu_read = 1'b0; cpu_address = '0;
    checks++;
    if (dbus_read !== 1'b1 || dbus_address !== {addr, 2'b00} || dbus_burstcount !== 7'd2) begin
      errors++;
      $display("FAIL %s_req: got rd=%b addr=%h bc=%0d, expected rd=1 addr=%h bc=2",
               name, dbus_read, dbus_address, dbus_burstcount, {addr, 2'b00});
    end
    dbus_waitrequest = 1'b1;
    step();
    dbus_waitrequest = 1'b0;
    if (same_cycle) begin
      dbus_readdatavalid = 1'b1; dbus_readdata = lo;
      step();
    end else begin
      step();
      checks++;
      if (dbus_read !== 1'b0) begin
        errors++; $display("FAIL %s_rd_drop: dbus_read=%b expected 0", name, dbus_read);
      end
      for (int i = 0; i < lat; i++) step();
      dbus_readdatavalid = 1'b1; dbus_readdata = lo;
      step();
    end
    checks++;
    if (cpu_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL %s_early_valid: readdatavalid=%b expected 0", name, cpu_readdatavalid);
    end
    dbus_readdata = hi;
    step();
    dbus_readdatavalid = 1'b0; dbus_readdata = 16'hFFFF;
    checks++;
    if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== exp) begin
      errors++;
      $display("FAIL %s_data: valid=%b data=%h expected valid=1 data=%h", name, cpu_readdatavalid, cpu_readdata, exp);
    end
    step();
    checks++;
    if (cpu_readdatavalid !== 1'b0 || rd_bursts !== 1) begin
      errors++;
      $display("FAIL %s_pulse: valid=%b bursts=%0d expected valid=0 bursts=1", name, cpu_readdatavalid, rd_bursts);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; init_done = 1'b0;
    cpu_address = '0; cpu_writedata = '0; cpu_byteenable = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    dbus_waitrequest = 1'b0; dbus_readdata = '0; dbus_readdatavalid = 1'b0;
    @(negedge clk);
    step(); step();
    checks++;
    if (dbus_read !== 1'b0 || dbus_write !== 1'b0 || cpu_readdatavalid !== 1'b0 || cpu_readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: rd=%b wr=%b rv=%b rdata=%h expected all 0",
               dbus_read, dbus_write, cpu_readdatavalid, cpu_readdata);
    end
    checks++;
    if (dbus_address !== '0 || dbus_writedata !== '0 || dbus_byteenable !== '0 || dbus_burstcount !== 7'd2) begin
      errors++;
      $display("FAIL reset_dbus: addr=%h wd=%h be=%b bc=%0d expected 0 0 0 2",
               dbus_address, dbus_writedata, dbus_byteenable, dbus_burstcount);
    end
    rst = 1'b1;
    step();
    checks++;
    if (cpu_waitrequest !== 1'b1) begin
      errors++; $display("FAIL reset_no_init: waitrequest=%b expected 1", cpu_waitrequest);
    end
  endtask

  task automatic test_rw_collision();
    clear_log();
    cpu_address = 23'h000005; cpu_writedata = 32'hAABBCCDD; cpu_byteenable = 4'hF;
    cpu_read = 1'b1; cpu_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cpu_waitrequest, dbus_write, dbus_read} !== 3'b100) begin
        errors++;
        $display("FAIL hold_off: waitreq=%b wr=%b rd=%b expected 1 0 0", cpu_waitrequest, dbus_write, dbus_read);
      end
      step();
    end
    init_done = 1'b1;
    #1;
    checks++;
    if (cpu_waitrequest !== 1'b0) begin
      errors++; $display("FAIL init_release: waitrequest=%b expected 0", cpu_waitrequest);
    end
    step();
    cpu_read = 1'b0; cpu_write = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (b_addr.size() !== 2 || rd_bursts !== 0) begin
      errors++;
      $display("FAIL collision_count: beats=%0d reads=%0d expected 2 0", b_addr.size(), rd_bursts);
    end
    check_beat("collision_b0", 0, 25'h14, 16'hCCDD, 2'b11);
    check_beat("collision_b1", 1, 25'h14, 16'hAABB, 2'b11);
  endtask

  task automatic test_basic_write();
    int wait_hi;
    do_write(23'h000003, 32'h12345678, 4'hF, 0, wait_hi);
    checks++;
    if (wait_hi !== 2) begin
      errors++; $display("FAIL basic_waitreq: high %0d cycles expected 2", wait_hi);
    end
    check_beat("basic_b0", 0, 25'h0C, 16'h5678, 2'b11);
    check_beat("basic_b1", 1, 25'h0C, 16'h1234, 2'b11);
  endtask

  task automatic test_stalled_write();
    int wait_hi;
    do_write(23'h000003, 32'h12345678, 4'hF, 3, wait_hi);
    checks++;
    if (b_addr.size() !== 2) begin
      errors++; $display("FAIL stall_count: beats=%0d expected 2", b_addr.size());
    end
    check_beat("stall_b0", 0, 25'h0C, 16'h5678, 2'b11);
    check_beat("stall_b1", 1, 25'h0C, 16'h1234, 2'b11);
  endtask

  task automatic test_byteenable();
    int wait_hi;
    do_write(23'h000010, 32'hA1B2C3D4, 4'b1001, 1, wait_hi);
    check_beat("be_b0", 0, 25'h40, 16'hC3D4, 2'b01);
    check_beat("be_b1", 1, 25'h40, 16'hA1B2, 2'b10);
    do_write(23'h000011, 32'h0BADF00D, 4'b0000, 0, wait_hi);
    check_beat("be0_b0", 0, 25'h44, 16'hF00D, 2'b00);
    check_beat("be0_b1", 1, 25'h44, 16'h0BAD, 2'b00);
  endtask

  task automatic test_read();
    // A stray readdatavalid while idle must be ignored.
    dbus_readdatavalid = 1'b1; dbus_readdata = 16'h5A5A;
    step(); step();
    dbus_readdatavalid = 1'b0;
    checks++;
    if (cpu_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL stray_valid: readdatavalid=%b expected 0", cpu_readdatavalid);
    end
    do_read("read", 23'h000003, 2, 1'b0, 16'h5678, 16'h1234, 32'h12345678);
    do_read("read_fast", 23'h000010, 0, 1'b1, 16'hC3D4, 16'hA1B2, 32'hA1B2C3D4);
  endtask

  task automatic test_reset_mid_burst();
    clear_log();
    cpu_address = 23'h000020; cpu_writedata = 32'hCAFEF00D; cpu_byteenable = 4'hF; cpu_write = 1'b1;
    step();
    cpu_write = 1'b0;
    step();
    dbus_waitrequest = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (dbus_write !== 1'b0 || cpu_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: dbus_write=%b waitrequest=%b expected 0 0", dbus_write, cpu_waitrequest);
    end
    rst = 1'b1; dbus_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (b_addr.size() !== 1 || dbus_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_abandon: beats=%0d dbus_write=%b expected 1 0", b_addr.size(), dbus_write);
    end
    do_read("read_after_rst", 23'h000003, 1, 1'b0, 16'h5678, 16'h1234, 32'h12345678);
  endtask

  initial begin
    test_reset();
    test_rw_collision();
    test_basic_write();
    test_stalled_write();
    test_byteenable();
    test_read();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
